// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter/sequencer shared by fetch and data stages.
// Define ARB_STATS_EN to build the saturating grant/stall performance counters.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              flush_f,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall_f,
    output logic              stall_m,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  perf_dgnt,
    output logic [CNT_W-1:0]  perf_ignt,
    output logic [CNT_W-1:0]  perf_stall
);

    // state | meaning
    // IDLE  | no transaction; data wins a simultaneous request
    // DATA  | load/store in flight on the memory port
    // FETCH | instruction read in flight; may be dropped by flush_f
    typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

    state_t state;
    logic   dropFlag;
    logic   grantD;
    logic   grantI;
    logic   done;

    // A completing requester is never re-granted on the same edge.
    always_comb begin
        grantD = 1'b0;
        grantI = 1'b0;
        case (state)
            IDLE: begin
                if (d_req)
                    grantD = 1'b1;
                else if (if_req && !flush_f)
                    grantI = 1'b1;
            end
            DATA:    grantI = mem_ready && if_req && !flush_f;
            FETCH:   grantD = mem_ready && d_req;
            default: ;
        endcase
    end

    assign done     = (state != IDLE) && mem_ready;
    assign d_valid  = (state == DATA) && mem_ready;
    assign if_valid = (state == FETCH) && mem_ready && !dropFlag && !flush_f;
    assign d_rdata  = mem_rdata;
    assign if_rdata = mem_rdata;
    assign stall_f  = if_req && !if_valid;
    assign stall_m  = d_req && !d_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            dropFlag  <= 1'b0;
        end else begin
            if (grantD) begin
                state     <= DATA;
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (grantI) begin
                state     <= FETCH;
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end else if (done) begin
                state   <= IDLE;
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end
            // The read still completes; only its valid pulse is withheld.
            if (state == FETCH) begin
                if (mem_ready)
                    dropFlag <= 1'b0;
                else if (flush_f)
                    dropFlag <= 1'b1;
            end
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_dgnt  <= '0;
            perf_ignt  <= '0;
            perf_stall <= '0;
        end else begin
            if (grantD && perf_dgnt != '1)
                perf_dgnt <= perf_dgnt + 1'b1;
            if (grantI && perf_ignt != '1)
                perf_ignt <= perf_ignt + 1'b1;
            if ((stall_f || stall_m) && perf_stall != '1)
                perf_stall <= perf_stall + 1'b1;
        end
    end
`else
    assign perf_dgnt  = '0;
    assign perf_ignt  = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; inputs change 1 ns after the rising
// edge and outputs are checked on the falling edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, flush_f, d_req, d_we, mem_ready;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_valid, d_valid, stall_f, stall_m, mem_req, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [15:0] perf_dgnt, perf_ignt, perf_stall;

    int nTests = 0;
    int nFail  = 0;

`ifdef ARB_STATS_EN
    localparam int EXP_DGNT  = 2;
    localparam int EXP_IGNT  = 2;
    localparam int EXP_STALL = 4;
`else
    localparam int EXP_DGNT  = 0;
    localparam int EXP_IGNT  = 0;
    localparam int EXP_STALL = 0;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .flush_f(flush_f),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid), .d_rdata(d_rdata),
        .stall_f(stall_f), .stall_m(stall_m),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .perf_dgnt(perf_dgnt), .perf_ignt(perf_ignt), .perf_stall(perf_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; if_req = 0; flush_f = 0; d_req = 0; d_we = 0; mem_ready = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
        nextCycle(); nextCycle(); sample();
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_valid", 32'(if_valid), 0);
        chk("rst_d_valid", 32'(d_valid), 0);
        chk("rst_perf_dgnt", 32'(perf_dgnt), 0);

        // fetch 0x10, ready at cycle 3
        nextCycle(); reset = 0; if_req = 1; if_addr = 32'h10; sample();
        chk("f1_c0_mem_req", 32'(mem_req), 0);
        chk("f1_c0_stall_f", 32'(stall_f), 1);
        nextCycle(); sample();
        chk("f1_c1_mem_req", 32'(mem_req), 1);
        chk("f1_c1_mem_addr", mem_addr, 32'h10);
        chk("f1_c1_if_valid", 32'(if_valid), 0);
        nextCycle(); sample();
        chk("f1_c2_mem_req", 32'(mem_req), 1);
        chk("f1_c2_stall_f", 32'(stall_f), 1);
        nextCycle(); mem_ready = 1; mem_rdata = 32'hE3A00001; sample();
        chk("f1_c3_mem_req", 32'(mem_req), 1);
        chk("f1_c3_if_valid", 32'(if_valid), 1);
        chk("f1_c3_if_rdata", if_rdata, 32'hE3A00001);
        chk("f1_c3_stall_f", 32'(stall_f), 0);
        nextCycle(); if_req = 0; sample();
        chk("idle_ready_mem_req", 32'(mem_req), 0);
        chk("idle_ready_if_valid", 32'(if_valid), 0);
        chk("idle_ready_d_valid", 32'(d_valid), 0);

        // simultaneous load 0x100 and fetch 0x20, ready latency 1
        nextCycle(); mem_ready = 0; d_req = 1; d_we = 0; d_addr = 32'h100;
        if_req = 1; if_addr = 32'h20; sample();
        chk("pri_c0_mem_req", 32'(mem_req), 0);
        chk("pri_c0_stall_m", 32'(stall_m), 1);
        nextCycle(); mem_ready = 1; mem_rdata = 32'h11111111; sample();
        chk("pri_c1_mem_addr", mem_addr, 32'h100);
        chk("pri_c1_d_valid", 32'(d_valid), 1);
        chk("pri_c1_d_rdata", d_rdata, 32'h11111111);
        chk("pri_c1_if_valid", 32'(if_valid), 0);
        nextCycle(); d_req = 0; mem_rdata = 32'h22222222; sample();
        chk("pri_c2_mem_req", 32'(mem_req), 1);
        chk("pri_c2_mem_addr", mem_addr, 32'h20);
        chk("pri_c2_if_valid", 32'(if_valid), 1);
        chk("pri_c2_if_rdata", if_rdata, 32'h22222222);
        chk("pri_c2_d_valid", 32'(d_valid), 0);
        nextCycle(); if_req = 0; mem_ready = 0; sample();
        chk("pri_c3_mem_req", 32'(mem_req), 0);

        // reset, then continuous alternation D, I, D, I
        nextCycle(); reset = 1;
        nextCycle(); reset = 0; d_req = 1; d_addr = 32'h200; if_req = 1;
        if_addr = 32'h30; mem_ready = 1; sample();
        chk("alt_c0_mem_req", 32'(mem_req), 0);
        nextCycle(); sample();
        chk("alt_c1_mem_addr", mem_addr, 32'h200);
        chk("alt_c1_d_valid", 32'(d_valid), 1);
        nextCycle(); d_addr = 32'h204; sample();
        chk("alt_c2_mem_addr", mem_addr, 32'h30);
        chk("alt_c2_if_valid", 32'(if_valid), 1);
        nextCycle(); if_addr = 32'h34; sample();
        chk("alt_c3_mem_addr", mem_addr, 32'h204);
        chk("alt_c3_d_valid", 32'(d_valid), 1);
        nextCycle(); d_req = 0; sample();
        chk("alt_c4_mem_addr", mem_addr, 32'h34);
        chk("alt_c4_if_valid", 32'(if_valid), 1);
        nextCycle(); if_req = 0; mem_ready = 0; sample();
        chk("alt_c5_mem_req", 32'(mem_req), 0);
        chk("alt_perf_dgnt", 32'(perf_dgnt), EXP_DGNT);
        chk("alt_perf_ignt", 32'(perf_ignt), EXP_IGNT);
        chk("alt_perf_stall", 32'(perf_stall), EXP_STALL);

        // flush mid-fetch, completion at cycle 4
        nextCycle(); if_req = 1; if_addr = 32'h50; sample();
        nextCycle(); sample();
        chk("fl_c1_mem_req", 32'(mem_req), 1);
        nextCycle(); flush_f = 1; sample();
        chk("fl_c2_if_valid", 32'(if_valid), 0);
        nextCycle(); flush_f = 0; sample();
        chk("fl_c3_mem_req", 32'(mem_req), 1);
        nextCycle(); mem_ready = 1; mem_rdata = 32'h33333333; sample();
        chk("fl_c4_mem_req", 32'(mem_req), 1);
        chk("fl_c4_mem_addr", mem_addr, 32'h50);
        chk("fl_c4_if_valid", 32'(if_valid), 0);
        nextCycle(); mem_ready = 0; if_addr = 32'h60; sample();
        chk("fl_c5_mem_req", 32'(mem_req), 0);
        nextCycle(); mem_ready = 1; mem_rdata = 32'h44444444; sample();
        chk("fl_c6_mem_addr", mem_addr, 32'h60);
        chk("fl_c6_if_valid", 32'(if_valid), 1);
        chk("fl_c6_if_rdata", if_rdata, 32'h44444444);

        // flush on the completion cycle, then flush blocking an idle grant
        nextCycle(); mem_ready = 0; if_addr = 32'h70; sample();
        nextCycle(); mem_ready = 1; flush_f = 1; sample();
        chk("flc_c1_mem_addr", mem_addr, 32'h70);
        chk("flc_c1_if_valid", 32'(if_valid), 0);
        nextCycle(); mem_ready = 0; if_addr = 32'h74; sample();
        chk("flc_c2_mem_req", 32'(mem_req), 0);
        nextCycle(); flush_f = 0; sample();
        chk("flc_c3_mem_req", 32'(mem_req), 0);
        nextCycle(); mem_ready = 1; mem_rdata = 32'h55555555; sample();
        chk("flc_c4_mem_addr", mem_addr, 32'h74);
        chk("flc_c4_if_valid", 32'(if_valid), 1);
        nextCycle(); if_req = 0; mem_ready = 0; sample();
        chk("flc_c5_mem_req", 32'(mem_req), 0);

        // store 0xDEADBEEF to 0x40
        nextCycle(); d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; sample();
        nextCycle(); sample();
        chk("st_c1_mem_we", 32'(mem_we), 1);
        chk("st_c1_mem_addr", mem_addr, 32'h40);
        chk("st_c1_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("st_c1_d_valid", 32'(d_valid), 0);
        chk("st_c1_stall_m", 32'(stall_m), 1);
        nextCycle(); mem_ready = 1; sample();
        chk("st_c2_mem_we", 32'(mem_we), 1);
        chk("st_c2_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("st_c2_d_valid", 32'(d_valid), 1);
        nextCycle(); d_req = 0; d_we = 0; mem_ready = 0; sample();
        chk("st_c3_d_valid", 32'(d_valid), 0);
        chk("st_c3_mem_req", 32'(mem_req), 0);
        chk("st_c3_mem_we", 32'(mem_we), 0);

        // reset during a stalled load
        nextCycle(); d_req = 1; d_addr = 32'h80; sample();
        nextCycle(); sample();
        chk("rd_c1_mem_req", 32'(mem_req), 1);
        nextCycle(); reset = 1; sample();
        chk("rd_c2_d_valid", 32'(d_valid), 0);
        nextCycle(); reset = 0; d_req = 0; sample();
        chk("rd_c3_mem_req", 32'(mem_req), 0);
        chk("rd_c3_mem_addr", mem_addr, 0);
        chk("rd_c3_d_valid", 32'(d_valid), 0);
        chk("rd_c3_perf_dgnt", 32'(perf_dgnt), 0);
        chk("rd_c3_perf_stall", 32'(perf_stall), 0);
        mem_ready = 1;
        sample();
        chk("rd_c3_idle_ready", 32'(d_valid), 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for a single-port unified instruction/data memory shared by the pipeline's fetch stage and memory stage. It accepts one fetch request and one data load/store request, issues one memory transaction at a time over a ready-based handshake, and returns completion pulses and stall signals to the pipeline. It sits between the CPU top-level pipeline and the memory model, replacing separate instruction and data memories.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- CNT_W, 16, width of the performance counters (used only with ARB_STATS_EN)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held with if_addr stable until if_valid
- if_addr  in  ADDR_W  fetch address (PC)
- flush_f  in  1  discard the in-flight or pending fetch (branch mispredict)
- if_valid  out  1  fetch complete this cycle
- if_rdata  out  DATA_W  instruction word, valid with if_valid
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_valid  out  1  data access complete this cycle
- d_rdata  out  DATA_W  load data, valid with d_valid
- stall_f  out  1  hold fetch/decode
- stall_m  out  1  hold memory stage and everything upstream
- mem_req  out  1  memory transaction active
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid with mem_ready
- mem_ready  in  1  transaction completes when mem_req && mem_ready
- perf_dgnt, perf_ignt, perf_stall  out  CNT_W  data grants, fetch grants, cycles with stall_f or stall_m

## Operation
- FSM states: IDLE, DATA, FETCH. Reset state IDLE.
- IDLE: if d_req -> DATA; else if if_req && !flush_f -> FETCH. Data has priority from IDLE.
- On entering DATA/FETCH, the winner's we/addr/wdata are latched into mem_* registers; mem_req = 1 in both busy states, 0 in IDLE.
- DATA, mem_ready=1: d_valid=1, d_rdata=mem_rdata (combinational). Next state FETCH if if_req && !flush_f, else IDLE.
- FETCH, mem_ready=1: if_valid=1 unless dropped, if_rdata=mem_rdata. Next state DATA if d_req, else IDLE.
- Alternation on completion: the completing requester is never re-granted on the same edge, so neither side starves.
- Flush: flush_f in FETCH (any cycle, including the completion cycle) sets a drop flag; the memory read still completes, if_valid is suppressed for it, and the flag clears on completion. flush_f in IDLE/DATA only blocks the fetch grant that cycle.
- Stores: mem_we=1 for the DATA transaction; d_rdata is don't-care.
- stall_f = if_req && !if_valid; stall_m = d_req && !d_valid (combinational).
- mem_req must not drop and mem_addr/we/wdata must not change until mem_ready is seen.

## Timing
- Reset values: mem_req/mem_we 0, mem_addr/mem_wdata 0, drop flag 0, counters 0; if_valid/d_valid 0.
- Request seen in IDLE at cycle 0 -> mem_req high from cycle 1. Memory ready at cycle k≥1 -> valid pulse in cycle k. Minimum latency is 2 cycles.
- Back-to-back alternation: the next mem_req transaction begins at cycle k+1 with no idle cycle.
- Reset in any state: IDLE next cycle, mem_req low, drop flag cleared, no valid pulse. The memory is reset on the same edge.
- mem_ready while IDLE is ignored.

## Configuration
- ARB_STATS_EN defined: perf_dgnt and perf_ignt increment on each grant (entry into DATA/FETCH). perf_stall increments each cycle stall_f || stall_m. All saturate at 2^CNT_W−1 and are cleared by reset.
- ARB_STATS_EN undefined: the counter registers are not built and the perf_* ports are tied to 0.

## Test plan
- if_req=1, if_addr=0x10; memory returns 0xE3A00001 with mem_ready at cycle 3 -> mem_req is 1 in cycles 1–3, mem_addr=0x10, if_valid=1 only in cycle 3, stall_f is 1 in cycles 0–2.
- In IDLE, d_req (load 0x100) and if_req (0x20) are asserted together, ready latency 1 -> DATA is granted first, d_valid at cycle 1, FETCH mem_req at cycle 2 with no gap, if_valid at cycle 2.
- d_req and if_req held continuously with new addresses after each valid -> grant order D, I, D, I; perf_dgnt=perf_ignt=2 after 4 transactions (ARB_STATS_EN).
- flush_f pulsed in cycle 2 of a FETCH that completes at cycle 4 -> mem_req is held to cycle 4, if_valid stays 0, and the next if_req is granted afterward.
- Store d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF held until mem_ready, d_valid pulses once.
- reset asserted during DATA with mem_ready=0 -> next cycle mem_req=0, state IDLE, no d_valid, counters are 0.
